horner_datapath: RTL and testbench
==================================

# horner_datapath

Arithmetic stage that consumes the sequencing outputs of the polynomial control block. It evaluates y = c10·x^10 + … + c1·x + c0 by Horner's rule: acc ← sat(acc·x + c[k]), one step per 16 cycles, using a bit-serial signed multiplier. It latches the sample on `srdyi`, takes `coeff_sel`/`sum_rst`/`sum_en` from control, and registers the result on `srdyo`.

## Interface
- `DW`, 16: sample, coefficient and accumulator width.
- `NCOEF`, 11: number of coefficients (degree + 1).
- `clk`  in  1  rising-edge clock.
- `GlobalReset`  in  1  asynchronous, active-low reset.
- `srdyi`  in  1  sample strobe; latch `x_in` this cycle.
- `x_in`  in  DW  sample, signed Q1.15.
- `coeff_sel`  in  4  coefficient index for the step in progress (10 down to 0).
- `sum_rst`  in  1  clear accumulator, phase and step counters.
- `sum_en`  in  1  advance serial multiplier phase.
- `srdyo`  in  1  result-ready strobe from control.
- `coeff_we`  in  1  coefficient file write enable.
- `coeff_waddr`  in  4  write index 0..10; 11..15 ignored.
- `coeff_wdata`  in  DW  coefficient, signed Q4.12.
- `y_out`  out  DW  result, signed Q4.12, held until the next capture.
- `y_vld`  out  1  one-cycle pulse, `y_out` newly valid.
- `busy`  out  1  high from `sum_rst` until 11 steps are complete.

## Operation
- Coefficient file: 11×DW registers. Written on `coeff_we`, usable at any time. A write and a read of the same index in the same cycle returns the old value.
- `srdyi`: x_reg ← `x_in`. `srdyi` does not touch the accumulator.
- `sum_rst`: acc ← 0, phase ← 0, step ← 0, busy ← 1. It has priority over `sum_en`.
- Step engine:
  - While `sum_en`=1 and step < 11, phase increments by 1 each cycle (mod 16), running radix-2 Booth over the 16 bits of x_reg, LSB first.
  - `sum_en`=0 freezes phase and partial product.
  - At phase 15 the step commits:
    - p = (acc·x_reg) >>> 15. Arithmetic shift, floor; 17-bit Q5.12.
    - s = p + sign-ext(c[`coeff_sel`]).
    - acc ← s saturated to [0x8000, 0x7FFF].
    - step ← step+1.
  - When step = 11: busy ← 0 and phase holds; further `sum_en` is ignored.
- `coeff_sel` is sampled only at the phase-15 commit. A value ≥ 11 at commit reads 0.
- `srdyo`: y_out ← acc and y_vld ← 1 on the next cycle. This happens regardless of busy; a premature `srdyo` outputs the partial acc.
- Restart: `srdyi` followed by `sum_rst` mid-computation aborts the current evaluation with no y_vld. The prior `y_out` is retained.
- Simultaneous `srdyi` and `srdyo`: both take effect (x_reg updates, acc captured).

## Timing
- Reset values: `y_out`=0, `y_vld`=0, `busy`=0, acc=0, x_reg=0, phase=0, step=0, coefficients=0.
- Reset is asynchronous on assertion and released synchronously (2-flop synchroniser upstream).
- With control's schedule:
  - `srdyi` at cycle 0.
  - `sum_rst` at cycle 1.
  - `sum_en` from cycle 18.
  - Commits at cycles 33, 49, …, 193 (18+16k+15), using `coeff_sel` 10..0.
  - `srdyo` at cycle 197; `y_vld` at cycle 198.
- Latency `srdyo`→`y_vld`: 1 cycle.
- Throughput: one evaluation per 198 cycles.

## Structure
- Shared package `horner_pkg`:
  - Constants: DW, NCOEF=11, STEP_CYCLES=16, FRAC_X=15, FRAC_C=12, SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000.
  - Coefficient index type (4-bit).
- One sub-module, `booth_serial_mult`:
  - Signed 16×16, one bit per enabled cycle.
  - Ports: `start`/`en`, `done` at phase 15, 32-bit product.
- The top level holds the coefficient file, acc, saturation, and output registers.

## Test plan
- c0=0x1000, others 0, x=0x2000, full control schedule → `y_out`=0x1000, `y_vld` high only at cycle 198.
- All c=0x1000, x=0x4000 (0.5) → `y_out`=0x1FFC (2 − 2^-10).
- c10=0x1000, others 0, x=0x8000 (−1.0) → `y_out`=0x1000; with c9=0x1000 as well → 0x0000.
- All c=0x7FFF, x=0x7FFF → saturates, `y_out`=0x7FFF; with all c=0x8000 → `y_out`=0x8000.
- `srdyi`+`sum_rst` reissued at cycle 100 with new x → no `y_vld` for the first evaluation; second result is correct for the new x.
- `GlobalReset` low at cycle 120 → all outputs zero immediately (asynchronous); after release, `busy`=0 and `y_vld` stays 0 until a new sequence.

Source files
------------

// File: rtl/horner_pkg.sv
// Shared constants and helpers for the Horner polynomial datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package horner_pkg;

    localparam int DW          = 16;   // sample, coefficient and accumulator width
    localparam int NCOEF       = 11;   // degree + 1
    localparam int STEP_CYCLES = 16;   // one Booth bit per cycle over a DW-bit multiplier
    localparam int FRAC_X      = 15;   // x is Q1.15
    localparam int FRAC_C      = 12;   // coefficients and acc are Q4.12

    localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;

    typedef logic [3:0] cidx_t;

    localparam cidx_t NCOEF_IDX = cidx_t'(NCOEF);

    // Clamp the 18-bit step sum back into the Q4.12 accumulator range.
    function automatic logic signed [DW-1:0] sat_acc(input logic signed [DW+1:0] v);
        logic signed [DW+1:0] w_hi;
        logic signed [DW+1:0] w_lo;
        w_hi = {2'b00, SAT_MAX};
        w_lo = {2'b11, SAT_MIN};
        if (v > w_hi) begin
            return SAT_MAX;
        end else if (v < w_lo) begin
            return SAT_MIN;
        end else begin
            return v[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/booth_serial_mult.sv
// Bit-serial signed DWxDW radix-2 Booth multiplier, multiplier bits scanned LSB first.
// Latency: 16 enabled cycles; o_product is the full product combinationally while o_done is high.
// Backpressure: i_en low freezes phase and partial product; i_start clears both.
// Ports: i_clk, i_rst_n (async active-low), i_start, i_en, i_a (multiplicand),
//        i_b (multiplier), o_done (phase 15 and enabled), o_product (2*DW signed).
module booth_serial_mult
    import horner_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_en,
    input  logic signed [DW-1:0]   i_a,
    input  logic signed [DW-1:0]   i_b,
    output logic                   o_done,
    output logic signed [2*DW-1:0] o_product
);

    logic        [3:0]      r_phase;
    logic signed [2*DW-1:0] r_part;

    logic                   w_prev;
    logic signed [2*DW-1:0] w_a_ext;
    logic signed [2*DW-1:0] w_shift;
    logic signed [2*DW-1:0] w_term;
    logic signed [2*DW-1:0] w_sum;

    // Booth pair (b[i], b[i-1]) with b[-1] = 0. The MSB pair subtracts 2^15*a,
    // which supplies the negative weight of the sign bit.
    assign w_prev  = (r_phase == 4'd0) ? 1'b0 : i_b[r_phase - 4'd1];
    assign w_a_ext = {{DW{i_a[DW-1]}}, i_a};
    assign w_shift = w_a_ext <<< r_phase;

    always_comb begin
        w_term = '0;
        case ({i_b[r_phase], w_prev})
            2'b01:   w_term = w_shift;
            2'b10:   w_term = -w_shift;
            default: w_term = '0;
        endcase
    end

    assign w_sum     = r_part + w_term;
    assign o_product = w_sum;
    assign o_done    = i_en && (r_phase == 4'(STEP_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_part  <= '0;
        end else if (i_start) begin
            r_phase <= '0;
            r_part  <= '0;
        end else if (i_en) begin
            r_phase <= r_phase + 4'd1;
            // The finished product is consumed this cycle; start the next step clean.
            r_part  <= o_done ? '0 : w_sum;
        end
    end

endmodule

// File: rtl/horner_datapath.sv
// Horner evaluator: acc <- sat(acc*x + c[k]) per 16-cycle step over 11 coefficients.
// Latency: srdyo -> y_vld 1 cycle; full evaluation 198 cycles under the control schedule.
// Backpressure: none; sum_en low stalls the serial multiplier, steps past the 11th are ignored.
// Ports: clk, GlobalReset (async active-low), srdyi/x_in (sample), coeff_sel/sum_rst/sum_en
//        (step control), srdyo (capture), coeff_we/coeff_waddr/coeff_wdata (coefficient file),
//        y_out/y_vld (result), busy.
module horner_datapath
    import horner_pkg::*;
(
    input  logic          clk,
    input  logic          GlobalReset,
    input  logic          srdyi,
    input  logic [DW-1:0] x_in,
    input  logic [3:0]    coeff_sel,
    input  logic          sum_rst,
    input  logic          sum_en,
    input  logic          srdyo,
    input  logic          coeff_we,
    input  logic [3:0]    coeff_waddr,
    input  logic [DW-1:0] coeff_wdata,
    output logic [DW-1:0] y_out,
    output logic          y_vld,
    output logic          busy
);

    logic signed [DW-1:0] r_coef [NCOEF];
    logic signed [DW-1:0] r_x;
    logic signed [DW-1:0] r_acc;
    cidx_t                r_step;
    logic                 r_busy;
    logic        [DW-1:0] r_y_out;
    logic                 r_y_vld;

    logic                   w_mul_en;
    logic                   w_done;
    logic signed [2*DW-1:0] w_prod;
    logic signed [DW-1:0]   w_coef;
    logic signed [DW:0]     w_p;
    logic signed [DW+1:0]   w_sum;

    // sum_rst wins over sum_en; once all steps are done the multiplier is frozen.
    assign w_mul_en = sum_en && !sum_rst && (r_step < NCOEF_IDX);

    booth_serial_mult u_mult (
        .i_clk     (clk),
        .i_rst_n   (GlobalReset),
        .i_start   (sum_rst),
        .i_en      (w_mul_en),
        .i_a       (r_acc),
        .i_b       (r_x),
        .o_done    (w_done),
        .o_product (w_prod)
    );

    // Out-of-range selects read as zero.
    assign w_coef = (coeff_sel < NCOEF_IDX) ? r_coef[coeff_sel] : '0;

    // Q4.12 * Q1.15 = Q5.27; dropping FRAC_X bits with floor returns to Q5.12.
    assign w_p   = w_prod[2*DW-1:FRAC_X];
    assign w_sum = {w_p[DW], w_p} + {{2{w_coef[DW-1]}}, w_coef};

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int i = 0; i < NCOEF; i++) begin
                r_coef[i] <= '0;
            end
        end else if (coeff_we && (coeff_waddr < NCOEF_IDX)) begin
            r_coef[coeff_waddr] <= coeff_wdata;
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_x     <= '0;
            r_acc   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_y_out <= '0;
            r_y_vld <= 1'b0;
        end else begin
            if (srdyi) begin
                r_x <= x_in;
            end

            if (sum_rst) begin
                r_acc  <= '0;
                r_step <= '0;
                r_busy <= 1'b1;
            end else if (w_done) begin
                r_acc  <= sat_acc(w_sum);
                r_step <= r_step + 4'd1;
                if (r_step == NCOEF_IDX - 4'd1) begin
                    r_busy <= 1'b0;
                end
            end

            // Captures whatever acc holds, finished or not.
            if (srdyo) begin
                r_y_out <= r_acc;
            end
            r_y_vld <= srdyo;
        end
    end

    assign y_out = r_y_out;
    assign y_vld = r_y_vld;
    assign busy  = r_busy;

endmodule

// File: tb/tb_horner_datapath.sv
module tb_horner_datapath;

    logic        clk;
    logic        GlobalReset;
    logic        srdyi;
    logic [15:0] x_in;
    logic [3:0]  coeff_sel;
    logic        sum_rst;
    logic        sum_en;
    logic        srdyo;
    logic        coeff_we;
    logic [3:0]  coeff_waddr;
    logic [15:0] coeff_wdata;
    logic [15:0] y_out;
    logic        y_vld;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    horner_datapath dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .srdyi       (srdyi),
        .x_in        (x_in),
        .coeff_sel   (coeff_sel),
        .sum_rst     (sum_rst),
        .sum_en      (sum_en),
        .srdyo       (srdyo),
        .coeff_we    (coeff_we),
        .coeff_waddr (coeff_waddr),
        .coeff_wdata (coeff_wdata),
        .y_out       (y_out),
        .y_vld       (y_vld),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        srdyi       = 1'b0;
        x_in        = '0;
        coeff_sel   = '0;
        sum_rst     = 1'b0;
        sum_en      = 1'b0;
        srdyo       = 1'b0;
        coeff_we    = 1'b0;
        coeff_waddr = '0;
        coeff_wdata = '0;
    endtask

    task automatic wr_coef(input int idx, input logic [15:0] val);
        coeff_we    = 1'b1;
        coeff_waddr = 4'(idx);
        coeff_wdata = val;
        @(posedge clk); #1;
        coeff_we    = 1'b0;
    endtask

    task automatic set_all(input logic [15:0] val);
        for (int i = 0; i < 11; i++) wr_coef(i, val);
    endtask

    // Drives the control schedule: srdyi@0, sum_rst@1, sum_en 18..en_end,
    // coeff_sel 10..0 per 16-cycle step, srdyo@197. abort_at>0 stops early
    // (no srdyo) and exp_y is then the value y_out must still hold.
    task automatic run_eval(input string tag, input logic [15:0] x, input int abort_at,
                            input int en_end, input bit bad_sel, input logic [15:0] exp_y);
        int pulses;
        int pulse_cyc;
        pulses    = 0;
        pulse_cyc = -1;
        for (int c = 0; c <= 197; c++) begin
            if (abort_at > 0 && c == abort_at) break;
            srdyi     = (c == 0);
            x_in      = (c == 0) ? x : 16'h0;
            sum_rst   = (c == 1);
            sum_en    = (c >= 18) && (c <= en_end);
            coeff_sel = (c >= 18 && c <= 193) ? 4'(10 - (c - 18) / 16) : 4'd0;
            if (bad_sel && c >= 178 && c <= 193) coeff_sel = 4'd12;
            srdyo     = (c == 197);
            @(posedge clk); #1;
            if (y_vld) begin
                pulses++;
                pulse_cyc = c + 1;
            end
            if (c == 2)   chk({tag, "_busy_start"}, busy, 1);
            if (c == 192) chk({tag, "_busy_last"}, busy, 1);
            if (c == 193) chk({tag, "_busy_done"}, busy, 0);
        end
        idle_inputs();
        if (abort_at > 0) begin
            chk({tag, "_abort_no_vld"}, pulses, 0);
            chk({tag, "_abort_yout_held"}, y_out, exp_y);
        end else begin
            chk({tag, "_vld_count"}, pulses, 1);
            chk({tag, "_vld_cycle"}, pulse_cyc, 198);
            chk({tag, "_y"}, y_out, exp_y);
            @(posedge clk); #1;
            chk({tag, "_vld_drop"}, y_vld, 0);
        end
    endtask

    initial begin
        int late_vld;
        int late_busy;
        idle_inputs();
        GlobalReset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        GlobalReset = 1'b1;
        @(posedge clk); #1;
        chk("rst_y_out", y_out, 0);
        chk("rst_y_vld", y_vld, 0);
        chk("rst_busy", busy, 0);

        // Only c0: result is c0 regardless of x.
        wr_coef(0, 16'h1000);
        run_eval("c0only", 16'h2000, 0, 193, 1'b0, 16'h1000);

        // Select 12 on the final step must read zero instead of c0.
        run_eval("sel_oob", 16'h2000, 0, 193, 1'b1, 16'h0000);

        // Geometric series at x = 0.5; sum_en held past the 11th step is ignored.
        set_all(16'h1000);
        run_eval("half", 16'h4000, 0, 196, 1'b0, 16'h1FFC);

        // x = -1: (-1)^10 = 1, then adding c9 cancels to zero.
        set_all(16'h0000);
        wr_coef(10, 16'h1000);
        run_eval("neg1_c10", 16'h8000, 0, 193, 1'b0, 16'h1000);
        wr_coef(9, 16'h1000);
        run_eval("neg1_c9", 16'h8000, 0, 193, 1'b0, 16'h0000);

        // Saturation at both rails.
        set_all(16'h7FFF);
        run_eval("sat_pos", 16'h7FFF, 0, 193, 1'b0, 16'h7FFF);
        set_all(16'h8000);
        run_eval("sat_neg", 16'h7FFF, 0, 193, 1'b0, 16'h8000);

        // Restart at cycle 100 with a new sample.
        set_all(16'h1000);
        run_eval("abort", 16'h2000, 100, 193, 1'b0, 16'h8000);
        run_eval("restart", 16'h4000, 0, 193, 1'b0, 16'h1FFC);

        // Asynchronous reset mid-evaluation at cycle 120.
        run_eval("pre_rst", 16'h4000, 120, 193, 1'b0, 16'h1FFC);
        chk("pre_rst_busy", busy, 1);
        #3;
        GlobalReset = 1'b0;
        #1;
        chk("async_y_out", y_out, 0);
        chk("async_y_vld", y_vld, 0);
        chk("async_busy", busy, 0);
        @(posedge clk); @(posedge clk); #1;
        GlobalReset = 1'b1;
        late_vld  = 0;
        late_busy = 0;
        sum_en    = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (y_vld) late_vld++;
            if (busy)  late_busy++;
        end
        idle_inputs();
        chk("post_rst_vld", late_vld, 0);
        chk("post_rst_busy", late_busy, 0);

        // Coefficients were cleared by reset, so the result is zero.
        run_eval("coef_rst", 16'h4000, 0, 193, 1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
